pc_fetch_unit: RTL and testbench

//   Program-counter stage directly upstream of the word-addressed instruction memory. Drives IAddr
//   and receives the decoded op/immediate/targe fields of the fetched word. Computes the next PC:

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/next_pc_calc.sv | 40 ++++
 rtl/pc_fetch_unit.sv | 112 +++++++++++
 tb/tb_pc_fetch_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared next-PC select codes, fetch FSM encoding and halt opcode.
// Revision : 1.0
// ============================================================================
package cpu_pkg;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_JREG   = 2'b11;

    localparam logic [5:0] OP_HALT = 6'h3F;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_t;

    // Retired-instruction counter never wraps back to zero.
    function automatic logic [31:0] sat_inc32(input logic [31:0] val);
        return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/next_pc_calc.sv
`default_nettype none
// ============================================================================
// Module   : next_pc_calc
// Brief    : Combinational next-PC and link-address computation.
// Revision : 1.0
// ============================================================================
module next_pc_calc
    import cpu_pkg::*;
(
    input  logic [31:0] iaddr,
    input  logic [1:0]  pc_sel,
    input  logic        branch_cond,
    input  logic [15:0] immediate,
    input  logic [25:0] targe,
    input  logic [31:0] rs_data,
    output logic [31:0] next_pc,
    output logic [31:0] pc_plus4
);

    logic [31:0] w_pc_plus4;
    logic [31:0] w_branch_off;

    assign w_pc_plus4   = iaddr + 32'd4;
    assign w_branch_off = {{14{immediate[15]}}, immediate, 2'b00};
    assign pc_plus4     = w_pc_plus4;

    always_comb begin
        next_pc = w_pc_plus4;
        case (pc_sel)
            PC_SEQ:    next_pc = w_pc_plus4;
            PC_BRANCH: next_pc = branch_cond ? (w_pc_plus4 + w_branch_off) : w_pc_plus4;
            PC_JUMP:   next_pc = {w_pc_plus4[31:28], targe, 2'b00};
            // Register targets are forced word aligned.
            PC_JREG:   next_pc = rs_data & 32'hFFFF_FFFC;
            default:   next_pc = w_pc_plus4;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit
// Brief    : PC register, fetch FSM (boot/run/halt/fault) and retire counter.
//            Optional macro PC_BOUNDS_CHECK_EN enables out-of-range fault.
// Revision : 1.0
// ============================================================================
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 1024,
    parameter logic [5:0]  HALT_OP    = OP_HALT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic [1:0]  pc_sel,
    input  logic        branch_cond,
    input  logic [5:0]  op,
    input  logic [15:0] immediate,
    input  logic [25:0] targe,
    input  logic [31:0] rs_data,
    output logic [31:0] IAddr,
    output logic [31:0] pc_plus4,
    output logic        valid,
    output logic        halted,
    output logic        fault,
    output logic [31:0] instr_count
);

    fetch_state_t r_state;
    logic [31:0]  r_iaddr;
    logic [31:0]  r_count;
    logic         r_valid;
    logic         r_halted;
    logic [31:0]  w_next_pc;

    next_pc_calc u_next_pc_calc (
        .iaddr       (r_iaddr),
        .pc_sel      (pc_sel),
        .branch_cond (branch_cond),
        .immediate   (immediate),
        .targe       (targe),
        .rs_data     (rs_data),
        .next_pc     (w_next_pc),
        .pc_plus4    (pc_plus4)
    );

`ifdef PC_BOUNDS_CHECK_EN
    localparam logic [32:0] c_imem_bytes = 33'(IMEM_WORDS) << 2;
    logic r_fault;
    logic w_oob;
    // Extra bit keeps the limit exact when memory spans the full 4 GiB.
    assign w_oob = ({1'b0, w_next_pc} >= c_imem_bytes);
    assign fault = r_fault;
`else
    assign fault = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_BOOT;
            r_iaddr  <= RESET_PC;
            r_count  <= 32'd0;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
`ifdef PC_BOUNDS_CHECK_EN
            r_fault  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_BOOT: begin
                    r_state <= ST_RUN;
                    r_valid <= 1'b1;
                end
                ST_RUN: begin
                    if (!stall) begin
                        if (op == HALT_OP) begin
                            r_state  <= ST_HALT;
                            r_valid  <= 1'b0;
                            r_halted <= 1'b1;
                            r_count  <= sat_inc32(r_count);
                        end
`ifdef PC_BOUNDS_CHECK_EN
                        else if (w_oob) begin
                            r_state <= ST_FAULT;
                            r_valid <= 1'b0;
                            r_fault <= 1'b1;
                        end
`endif
                        else begin
                            r_iaddr <= w_next_pc;
                            r_count <= sat_inc32(r_count);
                        end
                    end
                end
                default: begin
                    // HALT and FAULT are terminal until reset.
                    r_state <= r_state;
                end
            endcase
        end
    end

    assign IAddr       = r_iaddr;
    assign valid       = r_valid;
    assign halted      = r_halted;
    assign instr_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_unit
// Brief    : Directed self-checking bench for pc_fetch_unit.
// Revision : 1.0
// ============================================================================
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic [1:0]  pc_sel;
    logic        branch_cond;
    logic [5:0]  op;
    logic [15:0] immediate;
    logic [25:0] targe;
    logic [31:0] rs_data;
    logic [31:0] IAddr;
    logic [31:0] pc_plus4;
    logic        valid;
    logic        halted;
    logic        fault;
    logic [31:0] instr_count;

    int total;
    int bad;
    logic [31:0] exp_count;

    pc_fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .pc_sel      (pc_sel),
        .branch_cond (branch_cond),
        .op          (op),
        .immediate   (immediate),
        .targe       (targe),
        .rs_data     (rs_data),
        .IAddr       (IAddr),
        .pc_plus4    (pc_plus4),
        .valid       (valid),
        .halted      (halted),
        .fault       (fault),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall       = 1'b0;
        pc_sel      = 2'b00;
        branch_cond = 1'b0;
        op          = 6'h00;
        immediate   = 16'h0000;
        targe       = 26'h0;
        rs_data     = 32'h0;
    endtask

    // Reset, then clock through BOOT so the DUT sits in RUN at PC 0.
    task automatic do_reset();
        idle_inputs();
        @(posedge clk);
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        step();
        exp_count = 32'd0;
    endtask

    task automatic set_pc(input logic [31:0] addr);
        idle_inputs();
        pc_sel  = 2'b11;
        rs_data = addr;
        step();
        exp_count = exp_count + 1;
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #12;
        total++; if (IAddr !== 32'h0) begin bad++; $display("FAIL reset_iaddr got=%h want=%h", IAddr, 32'h0); end
        total++; if ({valid, halted, fault} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {valid, halted, fault}); end
        total++; if (instr_count !== 32'h0) begin bad++; $display("FAIL reset_count got=%h want=0", instr_count); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        total++; if (valid !== 1'b0 || IAddr !== 32'h0) begin bad++; $display("FAIL boot_cycle valid=%b iaddr=%h want valid=0 iaddr=0", valid, IAddr); end
        step();
        total++; if (valid !== 1'b1 || IAddr !== 32'h0) begin bad++; $display("FAIL run_entry valid=%b iaddr=%h want valid=1 iaddr=0", valid, IAddr); end
        exp_count = 32'd0;
    endtask

    task automatic test_seq();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'h4; exp_pc[1] = 32'h8; exp_pc[2] = 32'hC;
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            step();
            exp_count = exp_count + 1;
            total++; if (IAddr !== exp_pc[i]) begin bad++; $display("FAIL seq_%0d got=%h want=%h", i, IAddr, exp_pc[i]); end
        end
        total++; if (instr_count !== 32'd3) begin bad++; $display("FAIL seq_count got=%0d want=3", instr_count); end
        total++; if (pc_plus4 !== 32'h10) begin bad++; $display("FAIL pc_plus4 got=%h want=%h", pc_plus4, 32'h10); end
    endtask

    task automatic test_branch();
        logic [15:0] imm_v  [3];
        logic        cond_v [3];
        logic [31:0] want_v [3];
        imm_v[0] = 16'hFFFC; cond_v[0] = 1'b1; want_v[0] = 32'h04;
        imm_v[1] = 16'hFFFC; cond_v[1] = 1'b0; want_v[1] = 32'h14;
        imm_v[2] = 16'h0003; cond_v[2] = 1'b1; want_v[2] = 32'h20;
        for (int i = 0; i < 3; i++) begin
            set_pc(32'h10);
            pc_sel      = 2'b01;
            immediate   = imm_v[i];
            branch_cond = cond_v[i];
            step();
            exp_count = exp_count + 1;
            total++; if (IAddr !== want_v[i]) begin bad++; $display("FAIL branch_%0d got=%h want=%h", i, IAddr, want_v[i]); end
        end
        total++; if (instr_count !== exp_count) begin bad++; $display("FAIL branch_count got=%0d want=%0d", instr_count, exp_count); end
        idle_inputs();
    endtask

    task automatic test_jump();
        do_reset();
`ifdef PC_BOUNDS_CHECK_EN
        // High targets lie outside instruction memory: expect a fault.
        set_pc(32'h0000_0100);
        pc_sel  = 2'b11;
        rs_data = 32'h3000_0010;
        step();
        total++; if (fault !== 1'b1 || IAddr !== 32'h100) begin bad++; $display("FAIL jreg_oob fault=%b iaddr=%h want fault=1 iaddr=100", fault, IAddr); end
        total++; if (instr_count !== exp_count) begin bad++; $display("FAIL jreg_oob_count got=%0d want=%0d", instr_count, exp_count); end
        do_reset();
        set_pc(32'h0000_0010);
        pc_sel = 2'b10;
        targe  = 26'h0000040;
        step();
        exp_count = exp_count + 1;
        total++; if (IAddr !== 32'h0000_0100) begin bad++; $display("FAIL jump got=%h want=%h", IAddr, 32'h0000_0100); end
`else
        set_pc(32'h3000_0010);
        pc_sel = 2'b10;
        targe  = 26'h0000040;
        step();
        exp_count = exp_count + 1;
        total++; if (IAddr !== 32'h3000_0100) begin bad++; $display("FAIL jump got=%h want=%h", IAddr, 32'h3000_0100); end
`endif
        idle_inputs();
        pc_sel  = 2'b11;
        rs_data = 32'h0000_0207;
        step();
        exp_count = exp_count + 1;
        total++; if (IAddr !== 32'h0000_0204) begin bad++; $display("FAIL jreg_align got=%h want=%h", IAddr, 32'h0000_0204); end
        idle_inputs();
    endtask

    task automatic test_stall();
        do_reset();
        set_pc(32'h8);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (IAddr !== 32'h8 || instr_count !== exp_count || valid !== 1'b1) begin
                bad++; $display("FAIL stall_%0d iaddr=%h cnt=%0d valid=%b want iaddr=8 cnt=%0d valid=1", i, IAddr, instr_count, valid, exp_count);
            end
        end
        stall = 1'b0;
        step();
        exp_count = exp_count + 1;
        total++; if (IAddr !== 32'hC || instr_count !== exp_count) begin bad++; $display("FAIL stall_release iaddr=%h cnt=%0d want iaddr=c cnt=%0d", IAddr, instr_count, exp_count); end
    endtask

    task automatic test_halt();
        do_reset();
        set_pc(32'h40);
        op     = 6'h3F;
        pc_sel = 2'b10;
        targe  = 26'h0000100;
        step();
        exp_count = exp_count + 1;
        total++; if (halted !== 1'b1 || valid !== 1'b0 || IAddr !== 32'h40) begin
            bad++; $display("FAIL halt_enter halted=%b valid=%b iaddr=%h want 1 0 40", halted, valid, IAddr);
        end
        total++; if (instr_count !== exp_count) begin bad++; $display("FAIL halt_count got=%0d want=%0d", instr_count, exp_count); end
        idle_inputs();
        step();
        step();
        total++; if (halted !== 1'b1 || IAddr !== 32'h40 || instr_count !== exp_count) begin
            bad++; $display("FAIL halt_hold halted=%b iaddr=%h cnt=%0d want 1 40 %0d", halted, IAddr, instr_count, exp_count);
        end
        // Reset pulse between edges must take effect immediately.
        #2 rst_n = 1'b0;
        #1;
        total++; if (IAddr !== 32'h0 || halted !== 1'b0 || instr_count !== 32'h0 || valid !== 1'b0) begin
            bad++; $display("FAIL async_reset iaddr=%h halted=%b cnt=%0d valid=%b want 0 0 0 0", IAddr, halted, instr_count, valid);
        end
        #1 rst_n = 1'b1;
        step();
        exp_count = 32'd0;
    endtask

    task automatic test_bounds();
        do_reset();
        set_pc(32'hFFC);
        step();
`ifdef PC_BOUNDS_CHECK_EN
        total++; if (fault !== 1'b1 || IAddr !== 32'hFFC || valid !== 1'b0) begin
            bad++; $display("FAIL bounds fault=%b iaddr=%h valid=%b want 1 ffc 0", fault, IAddr, valid);
        end
        total++; if (instr_count !== exp_count) begin bad++; $display("FAIL bounds_count got=%0d want=%0d", instr_count, exp_count); end
        step();
        total++; if (fault !== 1'b1 || IAddr !== 32'hFFC) begin bad++; $display("FAIL fault_hold fault=%b iaddr=%h", fault, IAddr); end
`else
        exp_count = exp_count + 1;
        total++; if (fault !== 1'b0 || IAddr !== 32'h1000) begin
            bad++; $display("FAIL bounds fault=%b iaddr=%h want 0 1000", fault, IAddr);
        end
        total++; if (instr_count !== exp_count) begin bad++; $display("FAIL bounds_count got=%0d want=%0d", instr_count, exp_count); end
`endif
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        exp_count = 32'd0;
        rst_n     = 1'b0;
        test_reset();
        test_seq();
        test_branch();
        test_jump();
        test_stall();
        test_halt();
        test_bounds();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
